// File: rtl/ultrasonic_array_if.sv
// Register-slot bus between a host and the ultrasonic array core.
// The host drives the strobes and address; the core answers on rd_data.
interface ultrasonic_array_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (output cs, read, write, addr, wr_data, input rd_data);
    modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/ultrasonic_array_core.sv
// Sequential ping scheduler for an array of ultrasonic rangers: one trigger at a time,
// echo width measured per channel, with a dead-time gap between pings against crosstalk.
module ultrasonic_echo_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_q,
    output logic dly_q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta   <= async_in;
            sync_q <= meta;
            dly_q  <= sync_q;
        end
    end
endmodule

module ultrasonic_array_core #(
    parameter int N_CH           = 4,
    parameter int CNT_W          = 22,
    parameter int TRIG_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 3_000_000,
    parameter int GAP_CYCLES     = 6_000_000
) (
    input  logic                clk,
    input  logic                reset,
    ultrasonic_array_if.slave   bus,
    output logic [N_CH-1:0]     trig,
    input  logic [N_CH-1:0]     echo
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LIM    = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GAP} state_t;

    state_t                      state;
    logic                        run, start_pend, seen_low;
    logic [N_CH-1:0]             mask, new_f, to_f, new_set, to_set;
    logic [CH_W-1:0]             ch, first_ch, nxt_ch;
    logic                        nxt_ok, to_evt;
    logic [CNT_W-1:0]            cnt;
    logic [N_CH-1:0][CNT_W-1:0]  result;
    logic [N_CH-1:0]             e_s, e_d;
    logic                        wr_ctrl, wr_clr;
    logic [N_CH-1:0]             wr_mask, clr_new, clr_to;

    for (genvar g = 0; g < N_CH; g++) begin : g_sync
        ultrasonic_echo_sync u_sync (
            .clk(clk), .reset(reset), .async_in(echo[g]), .sync_q(e_s[g]), .dly_q(e_d[g])
        );
    end

    function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] c);
        onehot = '0;
        onehot[c] = 1'b1;
    endfunction

    assign wr_ctrl = bus.cs && bus.write && (bus.addr == 5'd0);
    assign wr_clr  = bus.cs && bus.write && (bus.addr == 5'd2);
    assign wr_mask = bus.wr_data[8 +: N_CH];
    assign clr_new = wr_clr ? bus.wr_data[16 +: N_CH] : '0;
    assign clr_to  = wr_clr ? bus.wr_data[24 +: N_CH] : '0;

    // Lowest masked channel, and the next masked channel above the current one.
    always_comb begin
        first_ch = '0;
        nxt_ch   = ch;
        nxt_ok   = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i]) first_ch = CH_W'(i);
            if (mask[i] && i > int'(ch)) begin
                nxt_ch = CH_W'(i);
                nxt_ok = 1'b1;
            end
        end
        to_evt = ((state == WAIT_RISE) || (state == MEASURE)) && (cnt == TO_LIM);
        to_set = to_evt ? onehot(ch) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            trig       <= '0;
            run        <= 1'b0;
            mask       <= '0;
            start_pend <= 1'b0;
            seen_low   <= 1'b0;
            ch         <= '0;
            cnt        <= '0;
            new_f      <= '0;
            to_f       <= '0;
            new_set    <= '0;
            result     <= '0;
        end else begin
            new_set <= '0;
            new_f   <= (new_f & ~clr_new) | new_set;
            to_f    <= (to_f & ~clr_to) | to_set;
            if (wr_ctrl) begin
                run  <= bus.wr_data[0];
                mask <= wr_mask;
                if (bus.wr_data[1] && state == IDLE && wr_mask != '0) start_pend <= 1'b1;
            end
            case (state)
                IDLE: if ((run || start_pend) && mask != '0) begin
                    ch    <= first_ch;
                    trig  <= onehot(first_ch);
                    cnt   <= '0;
                    state <= TRIG;
                end
                TRIG: if (cnt == TRIG_LAST) begin
                    trig     <= '0;
                    cnt      <= '0;
                    seen_low <= 1'b0;
                    state    <= WAIT_RISE;
                end else cnt <= cnt + CNT_W'(1);
                // A rise only counts once the echo has been seen low inside this window.
                WAIT_RISE: if (to_evt) begin
                    result[ch] <= '1;
                    cnt        <= '0;
                    state      <= GAP;
                end else if (e_s[ch] && seen_low) begin
                    cnt   <= '0;
                    state <= MEASURE;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                    if (!e_s[ch]) seen_low <= 1'b1;
                end
                // Counting on the delayed copy includes the cycle the rise was detected in.
                MEASURE: if (to_evt) begin
                    result[ch] <= '1;
                    cnt        <= '0;
                    state      <= GAP;
                end else if (e_d[ch]) begin
                    cnt <= cnt + CNT_W'(1);
                end else begin
                    result[ch] <= cnt;
                    new_set    <= onehot(ch);
                    cnt        <= '0;
                    state      <= GAP;
                end
                GAP: if (cnt == GAP_LAST) begin
                    cnt <= '0;
                    if ((run || start_pend) && nxt_ok) begin
                        ch    <= nxt_ch;
                        trig  <= onehot(nxt_ch);
                        state <= TRIG;
                    end else if (run && mask != '0) begin
                        ch         <= first_ch;
                        trig       <= onehot(first_ch);
                        start_pend <= 1'b0;
                        state      <= TRIG;
                    end else begin
                        start_pend <= 1'b0;
                        state      <= IDLE;
                    end
                end else cnt <= cnt + CNT_W'(1);
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.rd_data = '0;
        case (bus.addr)
            5'd0: begin
                bus.rd_data[0]         = run;
                bus.rd_data[8 +: N_CH] = mask;
            end
            5'd1: begin
                bus.rd_data[0]          = (state != IDLE);
                bus.rd_data[8 +: CH_W]  = ch;
                bus.rd_data[16 +: N_CH] = new_f;
                bus.rd_data[24 +: N_CH] = to_f;
            end
            default: begin
                for (int k = 0; k < N_CH; k++)
                    if (bus.addr == 5'(8 + k)) bus.rd_data[CNT_W-1:0] = result[k];
            end
        endcase
    end
endmodule

// File: tb/tb_ultrasonic_array_core.sv
// Directed bench: bus reads and trigger pulses are checked against scoreboard queues
// filled by the stimulus thread; echo responders answer each trigger with a set width.
module tb_ultrasonic_array_core;
    localparam int N_CH = 4, CNT_W = 22, TRIG = 10, TO = 200, GAP = 50;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N_CH-1:0] trig;
    wire  [N_CH-1:0] echo;

    ultrasonic_array_if bus();

    ultrasonic_array_core #(
        .N_CH(N_CH), .CNT_W(CNT_W), .TRIG_CYCLES(TRIG),
        .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .trig(trig), .echo(echo)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] exp;
        string       name;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      trig_q[$];
    int      echo_w[N_CH] = '{default: 0};

    // Echo responders: 5 cycles after a trigger falls, hold echo high for echo_w cycles.
    for (genvar g = 0; g < N_CH; g++) begin : g_echo
        logic e = 1'b0;
        int   rises = 0;
        assign echo[g] = e;
        initial forever begin
            @(negedge trig[g]);
            if (echo_w[g] > 0 && !reset) begin
                repeat (5) @(posedge clk);
                #1 e = 1'b1;
                rises++;
                repeat (echo_w[g]) @(posedge clk);
                #1 e = 1'b0;
            end
        end
    end

    // Read monitor.
    always @(negedge clk) begin
        if (bus.cs && bus.read) begin
            if (rd_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_unexpected: addr %0d data 0x%08h with nothing expected", bus.addr, bus.rd_data);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                chk(e.name, bus.rd_data, e.exp);
            end
        end
    end

    // Trigger monitor: channel, width, one-hot and gap since the previous pulse.
    int width = 0, cur_ch = 0, since_fall = 0, have_prev = 0;
    always @(negedge clk) begin
        if (reset) begin
            width     = 0;
            have_prev = 0;
        end else if (trig != '0) begin
            if (width == 0) begin
                for (int k = 0; k < N_CH; k++) if (trig[k]) cur_ch = k;
                chk("trig_onehot", $countones(trig), 1);
                if (have_prev != 0) chk("trig_gap_ge_gap", since_fall >= GAP, 1);
            end
            width++;
        end else if (width != 0) begin
            if (trig_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL trig_unexpected: ch %0d width %0d with nothing expected", cur_ch, width);
            end else begin
                int ec;
                ec = trig_q.pop_front();
                chk("trig_ch", cur_ch, ec);
                chk("trig_width", width, TRIG);
            end
            width      = 0;
            have_prev  = 1;
            since_fall = 0;
        end else begin
            since_fall++;
        end
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk);
        #1 bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
        @(posedge clk);
        #1 bus.cs = 1'b0; bus.write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string nm);
        rd_q.push_back('{addr: a, exp: e, name: nm});
        @(posedge clk);
        #1 bus.cs = 1'b1; bus.read = 1'b1; bus.addr = a;
        @(posedge clk);
        #1 bus.cs = 1'b0; bus.read = 1'b0;
    endtask

    task automatic wait_trig(input int k, input string nm);
        int i;
        for (i = 0; i < 200 && !trig[k]; i++) @(negedge clk);
        chk(nm, trig[k], 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wr_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_trig", trig, 0);
        rd(0, 0, "rst_ctrl");
        rd(1, 0, "rst_status");
        for (int k = 0; k < N_CH; k++) rd(5'(8 + k), 0, $sformatf("rst_res%0d", k));
        rd(5, 0, "unmapped5");
        rd(12, 0, "unmapped12");

        // Single sweep over channels 0 and 2.
        echo_w[0] = 37; echo_w[2] = 120;
        trig_q.push_back(0); trig_q.push_back(2);
        wr(0, 32'h0000_0502);
        rd(1, 32'h0000_0001, "sweep_busy");
        rd(0, 32'h0000_0500, "ctrl_start_selfclr");
        repeat (450) @(posedge clk);
        rd(1, 32'h0005_0200, "sweep_status");
        rd(8, 37, "sweep_res0");
        rd(10, 120, "sweep_res2");
        rd(9, 0, "sweep_res1_untouched");
        wr(2, 32'h00FF_0000);
        rd(1, 32'h0000_0200, "w1c_new");

        // No echo on channel 1: timeout.
        echo_w[0] = 0; echo_w[1] = 0; echo_w[2] = 0;
        trig_q.push_back(1);
        wr(0, 32'h0000_0202);
        repeat (350) @(posedge clk);
        rd(1, 32'h0200_0100, "to_status");
        rd(9, 32'h003F_FFFF, "to_res1");
        wr(2, 32'hFFFF_0000);
        rd(1, 32'h0000_0100, "w1c_to");

        // Continuous 0,1,0,1; run cleared during the second channel-1 measurement.
        echo_w[0] = 20; echo_w[1] = 30;
        trig_q.push_back(0); trig_q.push_back(1); trig_q.push_back(0); trig_q.push_back(1);
        wr(0, 32'h0000_0301);
        for (int i = 0; i < 3000 && g_echo[1].rises < 2; i++) @(posedge clk);
        chk("cont_second_ch1_echo", g_echo[1].rises >= 2, 1);
        repeat (10) @(posedge clk);
        wr(0, 32'h0000_0300);
        rd(1, 32'h0003_0101, "cont_busy_after_clr");
        repeat (200) @(posedge clk);
        rd(1, 32'h0003_0100, "cont_idle");
        rd(8, 20, "cont_res0");
        rd(9, 30, "cont_res1");
        rd(0, 32'h0000_0300, "cont_ctrl");
        wr(2, 32'hFFFF_0000);
        rd(1, 32'h0000_0100, "w1c_cont");

        // W1C of timeout[0] on the exact cycle it sets: the set wins.
        echo_w[0] = 0; echo_w[1] = 0;
        trig_q.push_back(0);
        wr(0, 32'h0000_0102);
        wait_trig(0, "race_trig_seen");
        repeat (209) @(posedge clk);
        wr(2, 32'h0100_0000);
        repeat (80) @(posedge clk);
        rd(1, 32'h0100_0000, "race_set_wins");
        rd(8, 32'h003F_FFFF, "race_res0");
        wr(2, 32'h0100_0000);
        rd(1, 32'h0000_0000, "race_clr_next");

        // Mask bits above N_CH, and start with an empty mask.
        wr(0, 32'h0000_FF00);
        rd(0, 32'h0000_0F00, "mask_upper_ignored");
        wr(0, 32'h0000_0002);
        rd(1, 32'h0000_0000, "start_mask0_idle");
        repeat (5) @(posedge clk);
        rd(1, 32'h0000_0000, "start_mask0_still");

        // Reset asserted while channel 2 is triggering.
        wr(0, 32'h0000_0402);
        wait_trig(2, "rst_trig_seen");
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_trig_drop", trig, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        rd(1, 0, "post_rst_status");
        rd(0, 0, "post_rst_ctrl");
        for (int k = 0; k < N_CH; k++) rd(5'(8 + k), 0, $sformatf("post_rst_res%0d", k));

        repeat (5) @(posedge clk);
        chk("trig_q_drained", trig_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
